id_ex_stage_64: RTL

Decode-to-execute pipeline stage for the 64-bit RISC-V datapath. It sits directly upstream of `ALU_unit_64`. It registers decoded operands and control, selects the immediate for operand B, and applies EX-stage forwarding from EX/MEM and MEM/WB. It interlocks on load-use hazards and drives the ALU's A, B, ALUOp1/ALUOp0, funct7 and funct3 inputs with a valid/ready handshake.

---
 rtl/id_ex_stage_64_pkg.sv | 46 ++++
 rtl/id_ex_stage_64_if.sv | 64 ++++++
 rtl/forward_mux_64.sv | 22 ++
 rtl/id_ex_stage_64.sv | 106 ++++++++++
 4 files changed

// File: rtl/id_ex_stage_64_pkg.sv
`default_nettype none
// id_ex_stage_64_pkg: widths, register/ALUOp encodings and stage records shared by the ID/EX slice.
// Rev 1.0 - initial release. Build option: ID_EX_FORWARDING_EN (see id_ex_stage_64).
package id_ex_stage_64_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;

    localparam reg_addr_t  REG_X0      = '0;
    localparam logic [1:0] ALUOP_LD_SD = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // One write-back source (EX/MEM or MEM/WB) as seen by the forwarding muxes
    typedef struct packed {
        reg_addr_t rd;
        logic      reg_write;
        xword_t    result;
    } wb_bus_t;

    typedef struct packed {
        xword_t      rs1_data;
        xword_t      rs2_data;
        xword_t      imm;
        reg_addr_t   rs1_addr;
        reg_addr_t   rs2_addr;
        reg_addr_t   rd;
        logic        alu_src;
        logic        alu_op1;
        logic        alu_op0;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } stage_t;

    // x0 is hard-wired to zero, so a write to it never matches a source
    function automatic logic reg_hit(input reg_addr_t rd, input logic we, input reg_addr_t src);
        return we && (rd != REG_X0) && (rd == src);
    endfunction
endpackage
`default_nettype wire

// File: rtl/id_ex_stage_64_if.sv
`default_nettype none
// id_ex_stage_64_if: decode-side inputs, forwarding bus and ALU-side outputs of the ID/EX stage.
// Rev 1.0 - initial release.
interface id_ex_stage_64_if;
    import id_ex_stage_64_pkg::*;

    logic       in_valid;
    logic       in_ready;
    xword_t     rs1_data;
    xword_t     rs2_data;
    reg_addr_t  rs1_addr;
    reg_addr_t  rs2_addr;
    reg_addr_t  rd_addr;
    xword_t     imm;
    logic       alu_src;
    logic       alu_op1;
    logic       alu_op0;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       flush;
    logic       ex_ready;
    reg_addr_t  exmem_rd;
    logic       exmem_reg_write;
    xword_t     exmem_result;
    reg_addr_t  memwb_rd;
    logic       memwb_reg_write;
    xword_t     memwb_result;
    logic       out_valid;
    xword_t     A;
    xword_t     B;
    xword_t     store_data;
    logic       ALUOp1;
    logic       ALUOp0;
    logic [6:0] out_funct7;
    logic [2:0] out_funct3;
    reg_addr_t  out_rd;
    logic       out_reg_write;
    logic       out_mem_read;
    logic       out_mem_write;
    logic       out_branch;

    modport master (
        output in_valid, rs1_data, rs2_data, rs1_addr, rs2_addr, rd_addr, imm, alu_src,
               alu_op1, alu_op0, funct7, funct3, reg_write, mem_read, mem_write, branch,
               flush, ex_ready, exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        input  in_ready, out_valid, A, B, store_data, ALUOp1, ALUOp0, out_funct7,
               out_funct3, out_rd, out_reg_write, out_mem_read, out_mem_write, out_branch
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, rs1_addr, rs2_addr, rd_addr, imm, alu_src,
               alu_op1, alu_op0, funct7, funct3, reg_write, mem_read, mem_write, branch,
               flush, ex_ready, exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        output in_ready, out_valid, A, B, store_data, ALUOp1, ALUOp0, out_funct7,
               out_funct3, out_rd, out_reg_write, out_mem_read, out_mem_write, out_branch
    );
endinterface
`default_nettype wire

// File: rtl/forward_mux_64.sv
`default_nettype none
// forward_mux_64: picks the newest value of one source register; EX/MEM beats MEM/WB beats regfile.
// Rev 1.0 - initial release.
module forward_mux_64
    import id_ex_stage_64_pkg::*;
(
    input  wire reg_addr_t src,
    input  wire xword_t    reg_data,
    input  wire wb_bus_t   exmem,
    input  wire wb_bus_t   memwb,
    output xword_t         data
);
    always_comb begin
        data = reg_data;
        if (reg_hit(exmem.rd, exmem.reg_write, src)) begin
            data = exmem.result;
        end else if (reg_hit(memwb.rd, memwb.reg_write, src)) begin
            data = memwb.result;
        end
    end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage_64.sv
`default_nettype none
// id_ex_stage_64: ID/EX pipeline register feeding ALU_unit_64, with operand forwarding and hazard stall.
// Rev 1.0 - initial release. Define ID_EX_FORWARDING_EN for forwarding + load-use interlock;
// otherwise any RAW against EX or EX/MEM stalls until the write reaches the write-through regfile.
module id_ex_stage_64
    import id_ex_stage_64_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    id_ex_stage_64_if.slave bus
);
    stage_t r_stage;
    logic   r_valid;
    stage_t w_in;
    logic   w_stall;
    logic   w_in_ready;
    logic   w_fire;
    xword_t w_rs1_val;
    xword_t w_rs2_val;

    assign w_in = '{rs1_data: bus.rs1_data, rs2_data: bus.rs2_data, imm: bus.imm,
                    rs1_addr: bus.rs1_addr, rs2_addr: bus.rs2_addr, rd: bus.rd_addr,
                    alu_src: bus.alu_src, alu_op1: bus.alu_op1, alu_op0: bus.alu_op0,
                    funct7: bus.funct7, funct3: bus.funct3, reg_write: bus.reg_write,
                    mem_read: bus.mem_read, mem_write: bus.mem_write, branch: bus.branch};

`ifdef ID_EX_FORWARDING_EN
    wb_bus_t w_exmem;
    wb_bus_t w_memwb;
    logic    w_rs2_used;

    assign w_exmem = '{rd: bus.exmem_rd, reg_write: bus.exmem_reg_write, result: bus.exmem_result};
    assign w_memwb = '{rd: bus.memwb_rd, reg_write: bus.memwb_reg_write, result: bus.memwb_result};

    // Stores read rs2 as data even though B takes the immediate
    assign w_rs2_used = !bus.alu_src || bus.mem_write;
    assign w_stall    = r_valid && r_stage.mem_read && bus.in_valid &&
                        (reg_hit(r_stage.rd, 1'b1, bus.rs1_addr) ||
                         (w_rs2_used && reg_hit(r_stage.rd, 1'b1, bus.rs2_addr)));

    forward_mux_64 u_fwd_rs1 (
        .src      (r_stage.rs1_addr),
        .reg_data (r_stage.rs1_data),
        .exmem    (w_exmem),
        .memwb    (w_memwb),
        .data     (w_rs1_val)
    );

    forward_mux_64 u_fwd_rs2 (
        .src      (r_stage.rs2_addr),
        .reg_data (r_stage.rs2_data),
        .exmem    (w_exmem),
        .memwb    (w_memwb),
        .data     (w_rs2_val)
    );
`else
    logic w_raw_rs1;
    logic w_raw_rs2;
    logic unused_fwd;

    // MEM/WB is absent here: the regfile writes through, so that value is already on rsX_data
    assign w_raw_rs1 = reg_hit(r_stage.rd, r_valid && r_stage.reg_write, bus.rs1_addr) ||
                       reg_hit(bus.exmem_rd, bus.exmem_reg_write, bus.rs1_addr);
    assign w_raw_rs2 = reg_hit(r_stage.rd, r_valid && r_stage.reg_write, bus.rs2_addr) ||
                       reg_hit(bus.exmem_rd, bus.exmem_reg_write, bus.rs2_addr);
    assign w_stall   = bus.in_valid && (w_raw_rs1 || w_raw_rs2);
    assign w_rs1_val = r_stage.rs1_data;
    assign w_rs2_val = r_stage.rs2_data;

    assign unused_fwd = ^{bus.exmem_result, bus.memwb_rd, bus.memwb_reg_write, bus.memwb_result,
                          r_stage.rs1_addr, r_stage.rs2_addr};
`endif

    assign w_in_ready = (!r_valid || bus.ex_ready) && !w_stall && !bus.flush;
    assign w_fire     = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_stage <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_stage <= w_in;
        end else if (bus.ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_valid;
    assign bus.A             = w_rs1_val;
    assign bus.store_data    = w_rs2_val;
    assign bus.B             = r_stage.alu_src ? r_stage.imm : w_rs2_val;
    assign bus.ALUOp1        = r_stage.alu_op1;
    assign bus.ALUOp0        = r_stage.alu_op0;
    assign bus.out_funct7    = r_stage.funct7;
    assign bus.out_funct3    = r_stage.funct3;
    assign bus.out_rd        = r_stage.rd;
    assign bus.out_reg_write = r_stage.reg_write;
    assign bus.out_mem_read  = r_stage.mem_read;
    assign bus.out_mem_write = r_stage.mem_write;
    assign bus.out_branch    = r_stage.branch;
endmodule
`default_nettype wire
